// File: rtl/ula_seq_16bit.sv
// ---------------------------------------------------------------------------
// ula_seq_16bit
//
// Multi-cycle word-width sequencer for a 4-bit 74181-style ALU slice. One
// request is captured in IDLE. The slice is then fed one nibble per RUN cycle,
// least significant nibble first. The slice carry is chained into the next
// nibble, and the F outputs are collected into a WIDTH-bit result.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   start               : request strobe, sampled only in IDLE
//   op_a, op_b          : WIDTH-bit operands, captured with start
//   op_s, op_m, op_cin  : slice function select, mode (1 = logic), carry in
//   busy                : high while in RUN (NIBBLES cycles)
//   done                : one-cycle completion pulse (DONE state)
//   result              : registered word result, held until next completion
//   carry_out           : registered carry out of the last nibble
//   a_eq_b_all          : registered AND of the slice equality across nibbles
//   alu_a/b/s/m/cin     : drive to the external slice
//   alu_f/c_out/a_eq_b  : combinational answer from the slice
//
// Handshake: a request is accepted only when start is high on a rising edge
// while the FSM is in IDLE. start is ignored (not queued) in RUN and DONE.
// ---------------------------------------------------------------------------
module ula_seq_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       op_s,
    input  logic             op_m,
    input  logic             op_cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             a_eq_b_all,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_cin,
    input  logic [3:0]       alu_f,
    input  logic             alu_c_out,
    input  logic             alu_a_eq_b
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int KW      = $clog2(NIBBLES);
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("ula_seq_16bit: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    logic [1:0]       state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic [3:0]       cap_s;
    logic             cap_m;
    logic             cap_cin;
    logic [WIDTH-1:0] acc;
    logic             carry_reg;
    logic             eq_reg;

    // Bit offset of nibble k. k is held at 0 outside RUN, so the slice sees
    // the nibble-0 values whenever the sequencer is not running.
    logic [KW+1:0] nib_lsb;
    assign nib_lsb = {k, 2'b00};

    assign alu_a   = cap_a[nib_lsb +: 4];
    assign alu_b   = cap_b[nib_lsb +: 4];
    assign alu_s   = cap_s;
    assign alu_m   = cap_m;
    assign alu_cin = (k == '0) ? cap_cin : carry_reg;

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            k          <= '0;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_s      <= '0;
            cap_m      <= 1'b0;
            cap_cin    <= 1'b0;
            acc        <= '0;
            carry_reg  <= 1'b0;
            eq_reg     <= 1'b0;
            result     <= '0;
            carry_out  <= 1'b0;
            a_eq_b_all <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cap_a     <= op_a;
                        cap_b     <= op_b;
                        cap_s     <= op_s;
                        cap_m     <= op_m;
                        cap_cin   <= op_cin;
                        acc       <= '0;
                        carry_reg <= 1'b0;
                        eq_reg    <= 1'b1;
                        k         <= '0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc[nib_lsb +: 4] <= alu_f;
                    carry_reg         <= alu_c_out;
                    eq_reg            <= eq_reg & alu_a_eq_b;
                    if (k == K_LAST) begin
                        // The last nibble is still in flight on alu_f, so the
                        // result is assembled from it and the lower acc bits.
                        result     <= {alu_f, acc[WIDTH-5:0]};
                        carry_out  <= alu_c_out;
                        a_eq_b_all <= eq_reg & alu_a_eq_b;
                        k          <= '0;
                        state      <= ST_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_seq_16bit.sv
module tb_ula_seq_16bit;

  localparam int W = 16;
  localparam int N = W / 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start;
  logic [W-1:0] op_a, op_b;
  logic [3:0]   op_s;
  logic         op_m, op_cin;
  logic         busy, done, carry_out, a_eq_b_all;
  logic [W-1:0] result;
  logic [3:0]   alu_a, alu_b, alu_s, alu_f;
  logic         alu_m, alu_cin, alu_c_out, alu_a_eq_b;

  int checks = 0;
  int errors = 0;

  ula_seq_16bit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cin(op_cin),
    .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .a_eq_b_all(a_eq_b_all),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_c_out(alu_c_out), .alu_a_eq_b(alu_a_eq_b)
  );

  // ---------------- 74181 function table, word level ----------------
  // Arithmetic mode: F = X + Y + cin, with X/Y bitwise functions of A and B.
  // "minus one" entries use Y = all ones.
  function automatic logic [2*W-1:0] arith_xy(input logic [W-1:0] a, b, input logic [3:0] s);
    logic [W-1:0] x, y, ones;
    ones = '1;
    case (s)
      4'h0: begin x = a;       y = '0;     end
      4'h1: begin x = a | b;   y = '0;     end
      4'h2: begin x = a | ~b;  y = '0;     end
      4'h3: begin x = '0;      y = ones;   end
      4'h4: begin x = a;       y = a & ~b; end
      4'h5: begin x = a | b;   y = a & ~b; end
      4'h6: begin x = a;       y = ~b;     end
      4'h7: begin x = a & ~b;  y = ones;   end
      4'h8: begin x = a;       y = a & b;  end
      4'h9: begin x = a;       y = b;      end
      4'hA: begin x = a | ~b;  y = a & b;  end
      4'hB: begin x = a & b;   y = ones;   end
      4'hC: begin x = a;       y = a;      end
      4'hD: begin x = a | b;   y = a;      end
      4'hE: begin x = a | ~b;  y = a;      end
      default: begin x = a;    y = ones;   end
    endcase
    return {x, y};
  endfunction

  function automatic logic [W-1:0] logic_f(input logic [W-1:0] a, b, input logic [3:0] s);
    case (s)
      4'h0: return ~a;
      4'h1: return ~(a | b);
      4'h2: return ~a & b;
      4'h3: return '0;
      4'h4: return ~(a & b);
      4'h5: return ~b;
      4'h6: return a ^ b;
      4'h7: return a & ~b;
      4'h8: return ~a | b;
      4'h9: return ~(a ^ b);
      4'hA: return b;
      4'hB: return a & b;
      4'hC: return '1;
      4'hD: return a | ~b;
      4'hE: return a | b;
      default: return a;
    endcase
  endfunction

  // Whole-word reference: {result, carry_out, a_eq_b_all}
  function automatic logic [W+1:0] word_model(input logic [W-1:0] a, b, input logic [3:0] s,
                                              input logic m, cin);
    logic [2*W-1:0] xy;
    logic [W:0]     sum;
    if (m) return {logic_f(a, b, s), 1'b0, a == b};
    xy  = arith_xy(a, b, s);
    sum = {1'b0, xy[2*W-1:W]} + {1'b0, xy[W-1:0]} + {{W{1'b0}}, cin};
    return {sum[W-1:0], sum[W], a == b};
  endfunction

  // ---------------- external slice stand-in (combinational) ----------------
  always_comb begin
    logic [2*W-1:0] xy;
    logic [4:0]     s5;
    logic [W-1:0]   wa, wb;
    wa = {{(W-4){1'b0}}, alu_a};
    wb = {{(W-4){1'b0}}, alu_b};
    xy = arith_xy(wa, wb, alu_s);
    s5 = {1'b0, xy[W+3:W]} + {1'b0, xy[3:0]} + {4'b0, alu_cin};
    if (alu_m) begin
      alu_f     = logic_f(wa, wb, alu_s) & 4'hF;
      alu_c_out = 1'b0;
    end else begin
      alu_f     = s5[3:0];
      alu_c_out = s5[4];
    end
    alu_a_eq_b = (alu_a == alu_b);
  end

  // ---------------- reference timeline + scoreboard ----------------
  int           ecount = 0;
  int           acc_edge = -1;
  logic [W+1:0] exp_q[$];
  logic [W-1:0] m_result = '0;
  logic         m_carry = 1'b0;
  logic         m_eq = 1'b0;

  always @(posedge clk) begin
    logic [W+1:0] e;
    ecount++;
    if (rst) begin
      acc_edge = -1;
      exp_q.delete();
      m_result = '0;
      m_carry  = 1'b0;
      m_eq     = 1'b0;
    end else begin
      if (acc_edge >= 0 && ecount == acc_edge + N) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty at edge %0d", ecount);
        end else begin
          e = exp_q.pop_front();
          {m_result, m_carry, m_eq} = e;
        end
      end
      if (start && (acc_edge < 0 || ecount >= acc_edge + N + 2)) begin
        acc_edge = ecount;
        exp_q.push_back(word_model(op_a, op_b, op_s, op_m, op_cin));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // compare process: every cycle once the model has seen an edge
  always @(negedge clk) begin
    logic eb, ed;
    if (ecount > 0) begin
      eb = (acc_edge >= 0) && (ecount >= acc_edge) && (ecount < acc_edge + N);
      ed = (acc_edge >= 0) && (ecount == acc_edge + N);
      chk("busy", 32'(busy), 32'(eb));
      chk("done", 32'(done), 32'(ed));
      chk("result", 32'(result), 32'(m_result));
      chk("carry_out", 32'(carry_out), 32'(m_carry));
      chk("a_eq_b_all", 32'(a_eq_b_all), 32'(m_eq));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic [W-1:0] a, b, input logic [3:0] s, input logic m, cin,
                       input logic [W-1:0] er, input logic ec, input logic chk_eq, input logic ee,
                       input string tag);
    int busy_n;
    bit got;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; op_s = s; op_m = m; op_cin = cin;
    @(negedge clk);
    start = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); op_s = 4'($urandom); op_cin = 1'($urandom);
    busy_n = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (busy) busy_n++;
      if (done) got = 1;
      else @(negedge clk);
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(N));
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_carry"}, 32'(carry_out), 32'(ec));
    if (chk_eq) chk({tag, "_eq"}, 32'(a_eq_b_all), 32'(ee));
  endtask

  task automatic rand_op();
    int gap;
    logic [W-1:0] a, b;
    a = W'($urandom);
    b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
    gap = $urandom_range(0, 3);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; op_s = 4'($urandom); op_m = 1'($urandom);
    op_cin = 1'($urandom);
    @(negedge clk);
    start = 1'b0; op_a = W'($urandom);
    repeat (N + 1) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dn;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; op_cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_eq", 32'(a_eq_b_all), 32'd0);
    rst = 1'b0;

    do_op(16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0, "add");
    do_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, "wrap");
    do_op(16'h5000, 16'h0001, 4'b0110, 1'b0, 1'b1, 16'h4FFF, 1'b1, 1'b0, 1'b0, "sub");
    do_op(16'h0000, 16'h0001, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, "sub_borrow");
    do_op(16'hA5A5, 16'h0FF0, 4'b0110, 1'b1, 1'b1, 16'hAA55, 1'b0, 1'b1, 1'b0, "xor");
    do_op(16'h3C3C, 16'h3C3C, 4'b0110, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, "xor_eq");
    do_op(16'h3C3C, 16'h3C3D, 4'b0110, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, "xor_ne");

    // start held high with operands changing every cycle
    @(negedge clk);
    op_s = 4'b1001; op_m = 1'b0; op_cin = 1'b0; op_b = W'($urandom);
    start = 1'b1;
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      op_a = W'($urandom);
      @(negedge clk);
      if (done) dn++;
    end
    start = 1'b0;
    repeat (N + 2) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("held_start_done_count", 32'(dn), 32'd5);

    // reset in the second RUN cycle
    @(negedge clk);
    start = 1'b1; op_a = 16'h1111; op_b = 16'h2222; op_s = 4'b1001; op_m = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_eq", 32'(a_eq_b_all), 32'd0);
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    do_op(16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0, "after_abort");

    for (int i = 0; i < 60; i++) rand_op();
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
